// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register: parallel load, shifts, rotates and
// arithmetic right shift, plus a counted multi-shift burst controlled by
// a two-state IDLE/RUN machine. All state changes on the rising clock edge
// with a synchronous active-high clear.
module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             SR,
  input  logic             SL,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] Q,
  output logic             SRO,
  output logic             SLO,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             done_q;

  logic [CNT_W-1:0] n_d;
  logic [WIDTH-1:0] shr_d, shl_d, ror_d, rol_d, asr_d;

  // Candidate next values: clamped burst length and every shift flavour.
  always_comb begin
    n_d   = (32'(amt) > 32'(WIDTH)) ? CNT_W'(WIDTH) : amt;
    shr_d = {SR, q_q[WIDTH-1:1]};
    shl_d = {q_q[WIDTH-2:0], SL};
    ror_d = {q_q[0], q_q[WIDTH-1:1]};
    rol_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    asr_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
  end

  // Burst FSM and register update; a zero-length burst completes without
  // ever entering RUN, so done still pulses once per accepted start.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dir_q <= dir;
            if (n_d == '0) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= n_d;
              state_q <= RUN;
            end
          end else if (en) begin
            case (mode)
              3'b001:  q_q <= shr_d;
              3'b010:  q_q <= shl_d;
              3'b011:  q_q <= D;
              3'b100:  q_q <= ror_d;
              3'b101:  q_q <= rol_d;
              3'b110:  q_q <= asr_d;
              default: q_q <= q_q;
            endcase
          end
        end
        RUN: begin
          q_q <= dir_q ? shl_d : shr_d;
          if (cnt_q == CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign SRO  = q_q[0];
  assign SLO  = q_q[WIDTH-1];
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n (WIDTH=8): directed steps for the listed
// scenarios followed by random traffic, all compared against a cycle model.
module tb_univ_shift_reg_n;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          clr, en, SR, SL, start, dir;
  logic [2:0]    mode;
  logic [W-1:0]  D;
  logic [CW-1:0] amt;
  logic [W-1:0]  Q;
  logic          SRO, SLO, busy, done;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0] m_q    = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_rem  = 0;
  logic         m_dir  = 1'b0;

  univ_shift_reg_n #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .SR(SR), .SL(SL), .D(D),
    .start(start), .dir(dir), .amt(amt), .Q(Q), .SRO(SRO), .SLO(SLO),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: apply the behavioural rules for one edge using current inputs.
  task automatic model_edge();
    int n;
    if (clr) begin
      m_q = '0; m_busy = 0; m_done = 0; m_rem = 0;
    end else if (m_busy) begin
      if (m_dir) m_q = W'((int'(m_q) * 2) % 256 + int'(SL));
      else       m_q = W'(int'(m_q) / 2 + (SR ? 128 : 0));
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_busy = 0;
    end else begin
      m_done = 0;
      if (start) begin
        n = (int'(amt) > W) ? W : int'(amt);
        m_dir = dir;
        if (n == 0) m_done = 1;
        else begin m_busy = 1; m_rem = n; end
      end else if (en) begin
        case (mode)
          3'd1: m_q = W'(int'(m_q) / 2 + (SR ? 128 : 0));
          3'd2: m_q = W'((int'(m_q) * 2) % 256 + int'(SL));
          3'd3: m_q = D;
          3'd4: m_q = W'(int'(m_q) / 2 + (int'(m_q) % 2) * 128);
          3'd5: m_q = W'((int'(m_q) * 2) % 256 + int'(m_q) / 128);
          3'd6: m_q = W'(int'(m_q) / 2 + (int'(m_q) >= 128 ? 128 : 0));
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("Q",    32'(Q),    32'(m_q));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("SRO",  32'(SRO),  32'(m_q[0]));
    chk("SLO",  32'(SLO),  32'(m_q[W-1]));
  endtask

  task automatic load(input logic [W-1:0] v);
    start = 0; en = 1; mode = 3'd3; D = v;
    tick();
  endtask

  initial begin
    clr = 1; en = 1; mode = 3'd3; D = 8'hA5; SR = 0; SL = 0;
    start = 0; dir = 0; amt = '0;
    @(negedge clk);

    // clear overrides a load
    tick();
    chk("rst_Q", 32'(Q), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    clr = 0;

    // serial right shifts with SR=1
    load(8'hC3);
    mode = 3'd1; SR = 1;
    tick(); chk("shr1", 32'(Q), 32'hE1); chk("sro1", 32'(SRO), 32'h1);
    tick(); chk("shr2", 32'(Q), 32'hF0); chk("sro2", 32'(SRO), 32'h0);
    tick(); chk("shr3", 32'(Q), 32'hF8);
    tick(); chk("shr4", 32'(Q), 32'hFC);
    SR = 0;

    // rotates, arithmetic shift, enable low
    load(8'h81); mode = 3'd5; tick(); chk("rol", 32'(Q), 32'h03);
    load(8'h81); mode = 3'd4; tick(); chk("ror", 32'(Q), 32'hC0);
    load(8'h90); mode = 3'd6; tick(); chk("asr", 32'(Q), 32'hC8);
    en = 0; mode = 3'd2; tick(); chk("en0", 32'(Q), 32'hC8);

    // left burst of 3, with a start pulse during busy that must be ignored
    load(8'h0F);
    mode = 3'd0; start = 1; dir = 1; SL = 0; amt = CW'(3);
    tick(); chk("b_busy0", 32'(busy), 32'h1); chk("b_hold", 32'(Q), 32'h0F);
    start = 0; tick();
    start = 1; dir = 0; amt = CW'(7); tick();
    start = 0; tick();
    chk("b_q", 32'(Q), 32'h78); chk("b_done", 32'(done), 32'h1); chk("b_idle", 32'(busy), 32'h0);
    tick(); chk("b_done_off", 32'(done), 32'h0);

    // zero-length burst
    start = 1; amt = '0; tick();
    chk("z_done", 32'(done), 32'h1); chk("z_busy", 32'(busy), 32'h0); chk("z_q", 32'(Q), 32'h78);
    start = 0; tick();

    // oversize burst clamps to WIDTH
    load(8'hFF);
    en = 1; mode = 3'd0; start = 1; dir = 0; SR = 0; amt = CW'(12);
    tick(); start = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("big_q", 32'(Q), 32'h00); chk("big_done", 32'(done), 32'h1);
    tick();

    // clear mid-burst: no done, then a fresh burst is accepted
    load(8'hAA);
    mode = 3'd0; start = 1; dir = 1; SL = 1; amt = CW'(5);
    tick(); start = 0;
    tick(); tick();
    clr = 1; tick(); clr = 0;
    chk("ab_q", 32'(Q), 32'h00); chk("ab_busy", 32'(busy), 32'h0);
    tick(); chk("ab_nodone", 32'(done), 32'h0);
    start = 1; amt = CW'(2); tick(); chk("ab_restart", 32'(busy), 32'h1);
    start = 0; tick(); tick();

    // held start: new burst accepted in the done cycle
    start = 1; dir = 0; SR = 1; amt = CW'(1);
    for (int i = 0; i < 6; i++) tick();
    start = 0; tick(); tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      clr   = ($urandom_range(0, 49) == 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = 3'($urandom_range(0, 7));
      SR    = 1'($urandom_range(0, 1));
      SL    = 1'($urandom_range(0, 1));
      D     = W'($urandom_range(0, 255));
      start = ($urandom_range(0, 7) == 0);
      dir   = 1'($urandom_range(0, 1));
      amt   = CW'($urandom_range(0, 15));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
